// File: rtl/lfsr_pkg.sv
// Shared types and widths for the LFSR cipher stage and its helpers.
package lfsr_pkg;

    localparam int W_LFSR = 7;
    localparam int W_DATA = 8;
    localparam int W_CNT  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/lfsr_next.sv
// One Fibonacci LFSR step: shift left, feed back the parity of the tapped bits.
module lfsr_next
    import lfsr_pkg::*;
(
    input  logic [W_LFSR-1:0] state,
    input  logic [W_LFSR-1:0] tap,
    output logic [W_LFSR-1:0] next_state
);

    assign next_state = {state[W_LFSR-2:0], ^(state & tap)};

endmodule

// File: rtl/lfsr_cipher.sv
// Streaming LFSR XOR cipher with load/seed control, valid/ready handshakes,
// a one-entry output register and an end-of-message pulse.
module lfsr_cipher
    import lfsr_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [W_LFSR-1:0] Seed,
    input  logic [3:0]        TapSel,
    input  logic [W_CNT-1:0]  Length,
    output logic [3:0]        TapIndex,
    input  logic [W_LFSR-1:0] Tap,
    input  logic              InValid,
    input  logic [W_DATA-1:0] InData,
    output logic              InReady,
    output logic              OutValid,
    output logic [W_DATA-1:0] OutData,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done,
    output logic              SeedErr
);

    state_t              state_q, state_d;
    logic [3:0]          tap_index_q, tap_index_d;
    logic [W_LFSR-1:0]   lfsr_q, lfsr_d;
    logic [W_CNT-1:0]    remaining_q, remaining_d;
    logic                out_valid_q, out_valid_d;
    logic [W_DATA-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;
    logic                seed_err_q, seed_err_d;
    logic                in_ready;
    logic                accept;
    logic [W_LFSR-1:0]   lfsr_adv;

    lfsr_next u_lfsr_next (
        .state      (lfsr_q),
        .tap        (Tap),
        .next_state (lfsr_adv)
    );

    always_comb begin
        state_d     = state_q;
        tap_index_d = tap_index_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        seed_err_d  = 1'b0;

        // Load takes priority over a same-cycle byte, so ready is masked by it.
        in_ready = (state_q == RUN) && (!out_valid_q || OutReady) && !Load;
        accept   = InValid && in_ready;

        if (Load) begin
            tap_index_d = TapSel;
            lfsr_d      = Seed;
            remaining_d = Length;
            out_valid_d = 1'b0;
            if (Seed == '0) begin
                state_d    = IDLE;
                seed_err_d = 1'b1;
            end else if (Length == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            if (out_valid_q && OutReady) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                out_data_d  = InData ^ {{(W_DATA-W_LFSR){1'b0}}, lfsr_q};
                out_valid_d = 1'b1;
                lfsr_d      = lfsr_adv;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - W_CNT'(1);
                end
                if (remaining_q == W_CNT'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            tap_index_q <= '0;
            lfsr_q      <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_index_q <= tap_index_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign TapIndex = tap_index_q;
    assign InReady  = in_ready;
    assign OutValid = out_valid_q;
    assign OutData  = out_data_q;
    assign Busy     = (state_q == RUN);
    assign Done     = done_q;
    assign SeedErr  = seed_err_q;

endmodule

// File: tb/tb_lfsr_cipher.sv
// Self-checking bench for lfsr_cipher: vector table plus hand-written corner
// sequences, with output bytes checked through an expected-value queue.
module tb_lfsr_cipher;

    logic       Clk;
    logic       Reset;
    logic       Load;
    logic [6:0] Seed;
    logic [3:0] TapSel;
    logic [7:0] Length;
    logic [3:0] TapIndex;
    logic [6:0] Tap;
    logic       InValid;
    logic [7:0] InData;
    logic       InReady;
    logic       OutValid;
    logic [7:0] OutData;
    logic       OutReady;
    logic       Busy;
    logic       Done;
    logic       SeedErr;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [6:0] seed;
        logic [3:0] tap_sel;
        logic [7:0] din0, din1, din2;
        logic [7:0] dout0, dout1, dout2;
    } vec_t;

    vec_t vecs[4];

    lfsr_cipher dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Load),
        .Seed     (Seed),
        .TapSel   (TapSel),
        .Length   (Length),
        .TapIndex (TapIndex),
        .Tap      (Tap),
        .InValid  (InValid),
        .InData   (InData),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutReady (OutReady),
        .Busy     (Busy),
        .Done     (Done),
        .SeedErr  (SeedErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [6:0] tapOf(input logic [3:0] idx);
        case (idx)
            4'd0:    return 7'h60;
            4'd1:    return 7'h41;
            4'd2:    return 7'h7F;
            4'd3:    return 7'h03;
            default: return 7'h44;
        endcase
    endfunction

    // External tap table, combinational from the registered index.
    always_comb Tap = tapOf(TapIndex);

    function automatic vec_t mkVec(input logic [6:0] s, input logic [3:0] t,
                                   input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                   input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.seed = s; v.tap_sel = t;
        v.din0 = d0; v.din1 = d1; v.din2 = d2;
        v.dout0 = e0; v.dout1 = e1; v.dout2 = e2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every handshake on the output port must match the oldest expected byte.
    always @(negedge Clk) begin
        if (!Reset && !Load && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected no byte", OutData);
            end else begin
                checkOutput("out_byte", {24'h0, OutData}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic loadCipher(input logic [6:0] s, input logic [3:0] t, input logic [7:0] len);
        Load = 1'b1; Seed = s; TapSel = t; Length = len;
        @(posedge Clk); #1;
        Load = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] expected);
        bit ok = 0;
        InValid = 1'b1;
        InData  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (InReady) begin
                exp_q.push_back(expected);
                ok = 1;
            end
            @(posedge Clk); #1;
            if (ok) break;
        end
        InValid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        OutReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge Clk); #1;
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_valid", OutValid, 0);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        Reset = 1'b1; Load = 1'b0; Seed = '0; TapSel = '0; Length = '0;
        InValid = 1'b0; InData = '0; OutReady = 1'b1;

        vecs[0] = mkVec(7'h01, 4'd0, 8'h41, 8'h41, 8'h41, 8'h40, 8'h43, 8'h45);
        vecs[1] = mkVec(7'h7F, 4'd1, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h7E, 8'hFD);
        vecs[2] = mkVec(7'h55, 4'd2, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h2A, 8'hFF);
        vecs[3] = mkVec(7'h40, 4'd0, 8'h12, 8'h34, 8'h56, 8'h52, 8'h35, 8'h54);

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        checkOutput("rst_tapindex", TapIndex, 0);
        checkOutput("rst_outvalid", OutValid, 0);
        checkOutput("rst_outdata", OutData, 0);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_seederr", SeedErr, 0);
        checkOutput("rst_inready", InReady, 0);

        for (int v = 0; v < 4; v++) begin
            loadCipher(vecs[v].seed, vecs[v].tap_sel, 8'd3);
            checkOutput("vec_busy", Busy, 1);
            checkOutput("vec_tapindex", TapIndex, {28'h0, vecs[v].tap_sel});
            applyStimulus(vecs[v].din0, vecs[v].dout0);
            checkOutput("vec_done_early", Done, 0);
            applyStimulus(vecs[v].din1, vecs[v].dout1);
            applyStimulus(vecs[v].din2, vecs[v].dout2);
            checkOutput("vec_done", Done, 1);
            drain();
            checkOutput("vec_idle", Busy, 0);
        end

        // Seven zero bytes expose the raw keystream including the first feedback bit.
        begin
            logic [7:0] ks[7];
            ks[0] = 8'h01; ks[1] = 8'h02; ks[2] = 8'h04; ks[3] = 8'h08;
            ks[4] = 8'h10; ks[5] = 8'h20; ks[6] = 8'h41;
            loadCipher(7'h01, 4'd0, 8'd7);
            for (int k = 0; k < 7; k++) applyStimulus(8'h00, ks[k]);
            checkOutput("ks_done", Done, 1);
            drain();
        end

        loadCipher(7'h01, 4'd0, 8'd3);
        OutReady = 1'b0;
        applyStimulus(8'h00, 8'h01);
        InValid = 1'b1; InData = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checkOutput("bp_inready", InReady, 0);
            checkOutput("bp_hold", OutData, 8'h01);
            @(posedge Clk); #1;
        end
        OutReady = 1'b1;
        applyStimulus(8'hFF, 8'hFD);
        applyStimulus(8'h00, 8'h04);
        checkOutput("bp_done", Done, 1);
        drain();

        InValid = 1'b1; InData = 8'h5A;
        loadCipher(7'h00, 4'd3, 8'd5);
        checkOutput("seed0_err", SeedErr, 1);
        checkOutput("seed0_busy", Busy, 0);
        checkOutput("seed0_inready", InReady, 0);
        @(posedge Clk); #1;
        checkOutput("seed0_pulse", SeedErr, 0);
        checkOutput("seed0_inready2", InReady, 0);
        InValid = 1'b0;

        loadCipher(7'h05, 4'd1, 8'd0);
        checkOutput("len0_done", Done, 1);
        checkOutput("len0_busy", Busy, 0);
        InValid = 1'b1;
        @(posedge Clk); #1;
        checkOutput("len0_pulse", Done, 0);
        checkOutput("len0_inready", InReady, 0);
        checkOutput("len0_outvalid", OutValid, 0);
        InValid = 1'b0;

        loadCipher(7'h01, 4'd0, 8'd4);
        OutReady = 1'b0;
        applyStimulus(8'h00, 8'h01);
        checkOutput("reload_pending", OutValid, 1);
        InValid = 1'b1; InData = 8'h00;
        Load = 1'b1; Seed = 7'h10; TapSel = 4'd0; Length = 8'd2;
        @(negedge Clk);
        checkOutput("reload_inready", InReady, 0);
        @(posedge Clk); #1;
        Load = 1'b0; InValid = 1'b0;
        exp_q.delete();
        checkOutput("reload_cleared", OutValid, 0);
        checkOutput("reload_busy", Busy, 1);
        OutReady = 1'b1;
        applyStimulus(8'h00, 8'h10);
        checkOutput("reload_done_early", Done, 0);
        applyStimulus(8'h00, 8'h20);
        checkOutput("reload_done", Done, 1);
        drain();

        loadCipher(7'h01, 4'd2, 8'd5);
        OutReady = 1'b0;
        applyStimulus(8'h33, 8'h32);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_q.delete();
        checkOutput("abort_outvalid", OutValid, 0);
        checkOutput("abort_outdata", OutData, 0);
        checkOutput("abort_tapindex", TapIndex, 0);
        checkOutput("abort_busy", Busy, 0);
        checkOutput("abort_done", Done, 0);
        checkOutput("abort_seederr", SeedErr, 0);
        checkOutput("abort_inready", InReady, 0);
        OutReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
